alu_operand_seq: RTL and testbench
==================================

ALU_OPERAND_SEQ -- requirements
Module: alu_operand_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port din  input  WIDTH  shared load bus carrying operand A, then operand B, then the opcode in din[3:0].
REQ-005 SHALL have port din_valid  input  1  din holds a valid word.
REQ-006 SHALL have port din_ready  output  1  the block accepts din this cycle.
REQ-007 SHALL have port result  output  WIDTH  registered ALU result, wired to the downstream result latch din.
REQ-008 SHALL have port result_en  output  1  one-cycle strobe, wired to the downstream latch en.
REQ-009 SHALL have port zf  output  1  result equals zero; valid while result_en=1.
REQ-010 SHALL have port ovf  output  1  signed overflow on ADD or SUB; valid while result_en=1.
REQ-011 SHALL have port err  output  1  undefined opcode; valid while result_en=1.

Function
REQ-012 SHALL implement an FSM with states LOAD_A, LOAD_B, LOAD_OP, EXEC and DONE.
REQ-013 SHALL drive din_ready=1 only in LOAD_A, LOAD_B and LOAD_OP.
REQ-014 SHALL accept a word only when din_valid and din_ready are both 1 at a clk edge; otherwise it SHALL hold state and the captured values.
REQ-015 SHALL, on acceptance, capture A and advance LOAD_A->LOAD_B, capture B and advance LOAD_B->LOAD_OP, and capture din[3:0] and advance LOAD_OP->EXEC.
REQ-016 SHALL, in EXEC, register result, zf, ovf and err, then advance to DONE unconditionally.
REQ-017 SHALL assert result_en for exactly the DONE cycle, then advance to LOAD_A unconditionally.
REQ-018 SHALL give a latency of 2 cycles from opcode acceptance to result_en, and a throughput of one operation per 5 cycles with din_valid held high.
REQ-019 SHALL use opcodes 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed, result 1 or 0), 7 SLL and 8 SRL, with shift amount B[4:0].
REQ-020 SHALL wrap ADD and SUB modulo 2^WIDTH, and SHALL set ovf only for ADD or SUB with signed overflow.
REQ-021 SHALL, for opcodes 9 to 15, set result=0, err=1 and ovf=0.
REQ-022 SHALL hold result, zf, ovf and err stable outside EXEC, so that the downstream latch keeps its value.
REQ-023 SHALL ignore din bits [WIDTH-1:4] in LOAD_OP.

Reset
REQ-024 SHALL, on rst=1, immediately force state=LOAD_A, result=0, result_en=0, zf=0, ovf=0, err=0 and the A, B and opcode captures to 0, independent of clk.
REQ-025 SHALL, on rst=1 in any state (including mid-load or DONE), discard the partial operation and emit no result_en on release.
REQ-026 SHALL assert din_ready=1 on the first clock after rst deasserts.

Configuration
REQ-027 SHALL, with macro ALU_SHIFT_EN defined, implement SLL and SRL per REQ-019.
REQ-028 SHALL, without ALU_SHIFT_EN, include no shifter logic and treat opcodes 7 and 8 as undefined per REQ-021.

Structure
REQ-029 SHALL take the opcode constants, the 4-bit opcode type and the FSM state encoding from shared package alu_pkg.
REQ-030 SHALL place the combinational opcode datapath, including the ALU_SHIFT_EN guard, in sub-module alu_core, instantiated once.

Verification
REQ-031 SHALL cover: A=5, B=7, op=0 loaded back-to-back -> result_en 2 cycles after op accept, result=12, zf=0, ovf=0.
REQ-032 SHALL cover: A=0x7FFFFFFF, B=1, op=0 -> result=0x80000000, ovf=1; A=3, B=3, op=1 -> result=0, zf=1.
REQ-033 SHALL cover: din_valid toggled randomly between words -> captures advance only on valid&&ready, and the final result is unchanged.
REQ-034 SHALL cover: op=12 -> result=0, err=1; with ALU_SHIFT_EN undefined, A=1, B=4, op=7 -> err=1; with it defined -> result=16.
REQ-035 SHALL cover: rst pulsed after B is accepted -> all outputs 0 immediately, no result_en, and the next load starts at LOAD_A.
REQ-036 SHALL cover: A=0xFFFFFFFF, B=1, op=6 -> result=1 (signed -1 < 1).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand sequencer: opcode type and constants,
// plus the FSM state encoding used by alu_operand_seq.
package alu_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned STATE_W = 3;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_ADD = 4'd0;
  localparam opcode_t OP_SUB = 4'd1;
  localparam opcode_t OP_AND = 4'd2;
  localparam opcode_t OP_OR  = 4'd3;
  localparam opcode_t OP_XOR = 4'd4;
  localparam opcode_t OP_NOR = 4'd5;
  localparam opcode_t OP_SLT = 4'd6;
  localparam opcode_t OP_SLL = 4'd7;
  localparam opcode_t OP_SRL = 4'd8;

  typedef enum logic [STATE_W-1:0] {
    ST_LOAD_A  = 3'd0,
    ST_LOAD_B  = 3'd1,
    ST_LOAD_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational opcode datapath for alu_operand_seq.
// Ports: a, b (operands), op (4-bit opcode) -> result_c, zf_c, ovf_c, err_c.
// Macro ALU_SHIFT_EN: when defined, SLL/SRL are implemented (shift by b[4:0]);
// otherwise no shifter exists and opcodes 7/8 report err like any undefined op.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  opcode_t          op,
  output logic [WIDTH-1:0] result_c,
  output logic             zf_c,
  output logic             ovf_c,
  output logic             err_c
);

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] diff_c;
  logic             add_ovf_c;
  logic             sub_ovf_c;

  assign sum_c  = a + b;
  assign diff_c = a - b;

  // Signed overflow: operand signs agree (ADD) / differ (SUB) and result sign flips.
  assign add_ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1]  != a[WIDTH-1]);
  assign sub_ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);

  // Opcode decode; undefined opcodes give zero result with err set.
  always_comb begin
    result_c = '0;
    ovf_c    = 1'b0;
    err_c    = 1'b0;
    case (op)
      OP_ADD: begin
        result_c = sum_c;
        ovf_c    = add_ovf_c;
      end
      OP_SUB: begin
        result_c = diff_c;
        ovf_c    = sub_ovf_c;
      end
      OP_AND: result_c = a & b;
      OP_OR:  result_c = a | b;
      OP_XOR: result_c = a ^ b;
      OP_NOR: result_c = ~(a | b);
      OP_SLT: result_c = WIDTH'($signed(a) < $signed(b));
`ifdef ALU_SHIFT_EN
      OP_SLL: result_c = a << b[4:0];
      OP_SRL: result_c = a >> b[4:0];
`endif
      default: err_c = 1'b1;
    endcase
  end

  assign zf_c = (result_c == '0);

endmodule

// File: rtl/alu_operand_seq.sv
// Sequencer that loads A, B and an opcode over a shared bus, executes one ALU
// operation and strobes the registered result to a downstream latch.
// Ports: clk, rst (async active-high); din/din_valid/din_ready load handshake;
// result/result_en/zf/ovf/err registered result interface.
// Macro ALU_SHIFT_EN (passed through to alu_core) enables SLL/SRL.
module alu_operand_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_en,
  output logic             zf,
  output logic             ovf,
  output logic             err
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  opcode_t          op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zf_q, zf_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             result_en_q, result_en_d;
  logic             din_ready_q, din_ready_d;

  logic [WIDTH-1:0] core_result_c;
  logic             core_zf_c;
  logic             core_ovf_c;
  logic             core_err_c;
  logic             accept_c;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .result_c (core_result_c),
    .zf_c     (core_zf_c),
    .ovf_c    (core_ovf_c),
    .err_c    (core_err_c)
  );

  assign accept_c = din_valid && din_ready_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD_A;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      result_q    <= '0;
      zf_q        <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      result_en_q <= 1'b0;
      din_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      result_q    <= result_d;
      zf_q        <= zf_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      result_en_q <= result_en_d;
      din_ready_q <= din_ready_d;
    end
  end

  // Next state plus operand capture and result update; everything holds by default.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    zf_d     = zf_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    case (state_q)
      ST_LOAD_A: if (accept_c) begin
        a_d     = din;
        state_d = ST_LOAD_B;
      end
      ST_LOAD_B: if (accept_c) begin
        b_d     = din;
        state_d = ST_LOAD_OP;
      end
      ST_LOAD_OP: if (accept_c) begin
        op_d    = opcode_t'(din[OP_W-1:0]);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        result_d = core_result_c;
        zf_d     = core_zf_c;
        ovf_d    = core_ovf_c;
        err_d    = core_err_c;
        state_d  = ST_DONE;
      end
      ST_DONE: state_d = ST_LOAD_A;
      default: state_d = ST_LOAD_A;
    endcase
  end

  // Registered control outputs decoded from the upcoming state so they align with it.
  always_comb begin
    din_ready_d = 1'b0;
    result_en_d = 1'b0;
    case (state_d)
      ST_LOAD_A, ST_LOAD_B, ST_LOAD_OP: din_ready_d = 1'b1;
      ST_DONE:                          result_en_d = 1'b1;
      default: ;
    endcase
  end

  assign din_ready = din_ready_q;
  assign result    = result_q;
  assign result_en = result_en_q;
  assign zf        = zf_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Directed self-checking bench for alu_operand_seq (WIDTH=32).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_operand_seq;

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] result;
  logic        result_en;
  logic        zf;
  logic        ovf;
  logic        err;

  int passed = 0;
  int total  = 0;

  alu_operand_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .result    (result),
    .result_en (result_en),
    .zf        (zf),
    .ovf       (ovf),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Present one word; 'gap' idle cycles with junk on din precede it.
  task automatic push(input logic [31:0] w, input int gap, input string tag);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      din_valid = 1'b0;
      din       = 32'hDEAD_BEEF;
      chk({tag, ":ready_idle"}, 32'(din_ready), 32'd1);
    end
    @(negedge clk);
    chk({tag, ":ready_load"}, 32'(din_ready), 32'd1);
    din       = w;
    din_valid = 1'b1;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] opw,
                        input int gap, input logic [31:0] er,
                        input logic ez, input logic eo, input logic ee, input string tag);
    push(a, gap, tag);
    push(b, gap, tag);
    push(opw, gap, tag);
    @(negedge clk);                  // EXEC cycle
    din_valid = 1'b0;
    din       = 32'h0;
    chk({tag, ":en_exec"},    32'(result_en), 32'd0);
    chk({tag, ":ready_exec"}, 32'(din_ready), 32'd0);
    @(negedge clk);                  // DONE cycle, two cycles after op accept
    chk({tag, ":en_done"},    32'(result_en), 32'd1);
    chk({tag, ":result"},     result,         er);
    chk({tag, ":zf"},         32'(zf),        32'(ez));
    chk({tag, ":ovf"},        32'(ovf),       32'(eo));
    chk({tag, ":err"},        32'(err),       32'(ee));
    chk({tag, ":ready_done"}, 32'(din_ready), 32'd0);
    @(negedge clk);                  // back in LOAD_A, result held
    chk({tag, ":en_after"},   32'(result_en), 32'd0);
    chk({tag, ":hold"},       result,         er);
    chk({tag, ":ready_next"}, 32'(din_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    din       = 32'h0;
    din_valid = 1'b0;
    #1;
    chk("rst:result", result,          32'd0);
    chk("rst:en",     32'(result_en),  32'd0);
    chk("rst:zf",     32'(zf),         32'd0);
    chk("rst:ovf",    32'(ovf),        32'd0);
    chk("rst:err",    32'(err),        32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst:ready_after", 32'(din_ready), 32'd1);

    run_op(32'd5, 32'd7, 32'd0, 0, 32'd12, 1'b0, 1'b0, 1'b0, "add_5_7");
    run_op(32'h7FFF_FFFF, 32'd1, 32'd0, 0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "add_ovf");
    run_op(32'd3, 32'd3, 32'd1, 0, 32'd0, 1'b1, 1'b0, 1'b0, "sub_zero");
    run_op(32'h8000_0000, 32'd1, 32'd1, 0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, "sub_ovf");
    // Gaps with junk on din, and junk in the upper opcode bits.
    run_op(32'h0000_00F0, 32'h0000_0F0F, 32'hABCD_0003, 2, 32'h0000_0FFF, 1'b0, 1'b0, 1'b0, "or_gaps");
    run_op(32'hFF00_FF00, 32'h0F0F_0F0F, 32'd4, 1, 32'hF00F_F00F, 1'b0, 1'b0, 1'b0, "xor");
    run_op(32'hFFFF_0000, 32'h0000_FF00, 32'd5, 0, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, "nor");
    run_op(32'h00FF_00FF, 32'h0F0F_0F0F, 32'd2, 3, 32'h000F_000F, 1'b0, 1'b0, 1'b0, "and");
    run_op(32'hFFFF_FFFF, 32'd1, 32'd6, 0, 32'd1, 1'b0, 1'b0, 1'b0, "slt_neg");
    run_op(32'd1, 32'hFFFF_FFFF, 32'd6, 0, 32'd0, 1'b1, 1'b0, 1'b0, "slt_pos");
    run_op(32'd1, 32'd2, 32'd12, 0, 32'd0, 1'b1, 1'b0, 1'b1, "undef_12");
`ifdef ALU_SHIFT_EN
    run_op(32'd1, 32'd4, 32'd7, 0, 32'd16, 1'b0, 1'b0, 1'b0, "sll");
    run_op(32'h8000_0000, 32'h0000_0024, 32'd8, 0, 32'h0800_0000, 1'b0, 1'b0, 1'b0, "srl");
`else
    run_op(32'd1, 32'd4, 32'd7, 0, 32'd0, 1'b1, 1'b0, 1'b1, "sll_off");
    run_op(32'h8000_0000, 32'd4, 32'd8, 0, 32'd0, 1'b1, 1'b0, 1'b1, "srl_off");
`endif

    // Leave nonzero result/ovf behind, then reset mid-load after B is accepted.
    run_op(32'h7FFF_FFFF, 32'd1, 32'd0, 0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "pre_rst");
    push(32'd9, 0, "mid");
    push(32'd9, 0, "mid");
    @(negedge clk);
    din_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst:result", result,         32'd0);
    chk("midrst:en",     32'(result_en), 32'd0);
    chk("midrst:zf",     32'(zf),        32'd0);
    chk("midrst:ovf",    32'(ovf),       32'd0);
    chk("midrst:err",    32'(err),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst:no_en",  32'(result_en), 32'd0);
      chk("midrst:ready",  32'(din_ready), 32'd1);
    end
    // A fresh load must start at LOAD_A.
    run_op(32'd5, 32'd7, 32'd0, 0, 32'd12, 1'b0, 1'b0, 1'b0, "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
